ti_cic_post_decim: RTL
======================

// Module: ti_cic_post_decim
// PURPOSE
//  Second decimation stage fed by the 8x2 polyphase CIC combiner's two outputs (IN1 then IN2 in time order), one pair per CLK_adc1_2.
//  Order-2 CIC (M=1) decimates the 2-sample/clk stream by R=2**LOG2R and buffers results in a small FIFO.
//  Readout is valid/ready toward the downstream capture/serial interface; FIFO overrun raises a sticky flag.
// PARAMETERS
//  IW     11  input sample width (signed); matches upstream BW+5
//  LOG2R  3   log2 of decimation ratio R; legal 1..6 (R=8 default)
//  FD     4   FIFO depth in words, power of 2, >=2
//  OW     IW+2*LOG2R  output width (derived, full CIC bit growth, not overridable)
// PORTS
//  CLK_adc1_2  in   1       sole clock, rising edge
//  RES         in   1       asynchronous active-high reset
//  ENABLE      in   1       1: sample IN1/IN2 this edge; 0: filter frozen
//  IN1         in   IW      signed, earlier sample of pair
//  IN2         in   IW      signed, later sample of pair
//  CLR_OVF     in   1       synchronous clear of OVF
//  DOUT_READY  in   1       downstream accepts DOUT this edge
//  DOUT        out  OW      signed decimated sample (FIFO head)
//  DOUT_VALID  out  1       FIFO non-empty
//  FIFO_LVL    out  clog2(FD+1)  words currently held
//  OVF         out  1       sticky: a result was dropped (FIFO full)
// BEHAVIOUR
//  Reset (async, RES=1): integrators, combs, phase counter, FIFO pointers cleared; DOUT=0, DOUT_VALID=0, FIFO_LVL=0, OVF=0.
//  Arithmetic: all integrator/comb regs OW bits, two's-complement wrap (mod 2**OW) is intended and correct; no saturation.
//  Integrators, per enabled edge: a1=I1+IN1; b1=a1+IN2; I1<=b1; I2<=I2+a1+b1 (inputs sign-extended to OW).
//  Phase counter P: 0..R/2-1, increments on each enabled edge, wraps to 0; when P==R/2-1 at an enabled edge, the
//   updated I2 value is the decimated sample (one per R input samples).
//  ENABLE=0: I1, I2, P, combs hold; FIFO and handshake keep running (drain continues).
//  Comb (decimated rate, delay 1, two stages), one registered stage: c1=X-D1; y=c1-D2; D1<=X; D2<=c1.
//  Latency: completing pair captured at edge t -> comb result registered at t+1 -> written to FIFO at t+2;
//   with FIFO empty, DOUT_VALID rises and DOUT shows it after edge t+2.
//  First 2 outputs after reset are CIC start-up transients (comb delays start at 0); not suppressed.
//  Handshake: transfer when DOUT_VALID & DOUT_READY at edge; DOUT stable while VALID & !READY.
//  Push while full and no pop same edge: new word dropped, FIFO unchanged, OVF<=1.
//  Push and pop same edge: always accepted, including when full; FIFO_LVL unchanged.
//  Pop with FIFO empty: ignored (VALID=0).
//  OVF: set by drop, cleared by CLR_OVF; drop and CLR_OVF same edge -> OVF=1 (set wins).
//  Reset mid-operation: everything returns to reset values immediately; buffered words lost; no output on release
//   until a full new decimation period of enabled input.
// STRUCTURE
//  Shared package ti_cic_pkg: default IW/LOG2R/FD, function cic_ow(iw,log2r,order) for width calc, CIC_ORDER=2.
//  One sub-module: ti_sync_fifo (width OW, depth FD, push/pop/full/empty/level, drop-on-full handled by parent).
//  Integrator/comb/phase logic stays in this module.
// TESTING
//  DC: IN1=IN2=1, ENABLE=1, R=8, READY=1 -> DOUT sequence 36, 64, 64, 64... one word per 4 clocks.
//  Negative full scale: IN1=IN2=-1024 held -> after transients DOUT=-65536 steady, OVF stays 0.
//  Latency: after reset, 4 enabled pairs of 1 -> DOUT_VALID rises exactly 2 edges after 4th pair, DOUT=36.
//  Backpressure: READY=0, DC=1 for 5 outputs -> FIFO_LVL=4, 5th dropped, OVF=1; CLR_OVF pulse -> OVF=0; drain gives 36,64,64,64.
//  ENABLE gaps: ENABLE toggled 1/0 every edge, DC=1 -> same value sequence as DC test, output spacing 8 clocks.
//  Reset mid-stream: RES pulsed with 3 words in FIFO -> VALID=0, FIFO_LVL=0 asynchronously; restart reproduces 36,64.

Source files
------------

// File: rtl/ti_cic_pkg.sv
// Shared constants and width helper for the post-decimation CIC stage.
package ti_cic_pkg;

  localparam int IW_DEF    = 11;
  localparam int LOG2R_DEF = 3;
  localparam int FD_DEF    = 4;
  localparam int CIC_ORDER = 2;

  // Full CIC bit growth with differential delay M=1: order * log2(R) extra bits.
  function automatic int cic_ow(input int iw, input int log2r, input int order);
    return iw + order * log2r;
  endfunction

endpackage

// File: rtl/ti_sync_fifo.sv
// Small synchronous FIFO; push while full is accepted only together with a pop.
module ti_sync_fifo #(
  parameter int W   = 8,
  parameter int D   = 4,
  localparam int AW = $clog2(D),
  localparam int LW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(D));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage carries no reset; a word is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because D is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/ti_cic_post_decim.sv
// Order-2 CIC decimator (R = 2**LOG2R) on a two-samples-per-clock stream,
// followed by a valid/ready output FIFO with a sticky overrun flag.
module ti_cic_post_decim
  import ti_cic_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int LOG2R = LOG2R_DEF,
  parameter int FD    = FD_DEF,
  localparam int OW   = cic_ow(IW, LOG2R, CIC_ORDER),
  localparam int LW   = $clog2(FD + 1)
) (
  input  logic                 CLK_adc1_2,
  input  logic                 RES,
  input  logic                 ENABLE,
  input  logic signed [IW-1:0] IN1,
  input  logic signed [IW-1:0] IN2,
  input  logic                 CLR_OVF,
  input  logic                 DOUT_READY,
  output logic signed [OW-1:0] DOUT,
  output logic                 DOUT_VALID,
  output logic [LW-1:0]        FIFO_LVL,
  output logic                 OVF
);

  // Two samples arrive per clock, so one decimated output every R/2 enabled edges.
  localparam logic [LOG2R-1:0] PH_LAST = LOG2R'((1 << (LOG2R - 1)) - 1);

  logic signed [OW-1:0] i1, i2, d1, d2, y_q;
  logic signed [OW-1:0] in1_x, in2_x, a1, b1, c1, y;
  logic [LOG2R-1:0]     ph;
  logic                 dec_stb, y_stb;
  logic                 fifo_full, fifo_empty, push, pop, drop;
  logic [OW-1:0]        fifo_head;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    in1_x = {{(OW-IW){IN1[IW-1]}}, IN1};
    in2_x = {{(OW-IW){IN2[IW-1]}}, IN2};
    a1    = i1 + in1_x;
    b1    = a1 + in2_x;
    c1    = i2 - d1;
    y     = c1 - d2;
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK_adc1_2 or posedge RES) begin
    if (RES) begin
      i1      <= '0;
      i2      <= '0;
      ph      <= '0;
      dec_stb <= 1'b0;
    end else begin
      dec_stb <= ENABLE && (ph == PH_LAST);
      if (ENABLE) begin
        i1 <= b1;
        i2 <= i2 + a1 + b1;
        ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      end
    end
  end

  // Comb section runs once per decimated sample, on the I2 value captured by the strobe edge.
  always_ff @(posedge CLK_adc1_2 or posedge RES) begin
    if (RES) begin
      d1    <= '0;
      d2    <= '0;
      y_q   <= '0;
      y_stb <= 1'b0;
    end else begin
      y_stb <= dec_stb;
      if (dec_stb) begin
        d1  <= i2;
        d2  <= c1;
        y_q <= y;
      end
    end
  end

  assign pop  = ~fifo_empty & DOUT_READY;
  assign push = y_stb & (~fifo_full | pop);
  assign drop = y_stb & fifo_full & ~pop;

  always_ff @(posedge CLK_adc1_2 or posedge RES) begin
    if (RES)          OVF <= 1'b0;
    else if (drop)    OVF <= 1'b1;
    else if (CLR_OVF) OVF <= 1'b0;
  end

  ti_sync_fifo #(
    .W (OW),
    .D (FD)
  ) u_fifo (
    .clk   (CLK_adc1_2),
    .rst   (RES),
    .push  (push),
    .pop   (pop),
    .din   (y_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LVL)
  );

  assign DOUT_VALID = ~fifo_empty;
  assign DOUT       = fifo_empty ? '0 : signed'(fifo_head);

endmodule
